// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: linear frequency-sweep sequencer for the multi-waveform NCO.
// Steps freq from a start word toward an inclusive stop word (up or down),
// holding each value for a programmable dwell, single-shot or repeating.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   go, abort       start request (IDLE only), immediate stop (any state)
//   cfg_start/stop  first word / inclusive limit (FW bits)
//   cfg_step        unsigned step magnitude (FW bits)
//   cfg_dwell       cycles per step, 0 behaves as 1 (DW bits)
//   cfg_repeat      restart at cfg_start after each completed sweep
//   freq            tuning word to the NCO
//   accum_rst       one-cycle NCO accumulator reset at each sweep start
//   sweep_start     one-cycle marker coincident with accum_rst
//   busy            high while sweeping
//   done            one-cycle pulse when a non-repeating sweep completes
// Optional build macro NCO_SWEEP_CNT_EN adds:
//   cfg_count       number of sweeps in repeat mode (0 = unlimited)
//   sweep_cnt       completed sweeps since the last go, saturating
module nco_sweep_ctrl #(
    parameter int unsigned FW = 28,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          abort,
    input  logic [FW-1:0] cfg_start,
    input  logic [FW-1:0] cfg_stop,
    input  logic [FW-1:0] cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic          cfg_repeat,
    output logic [FW-1:0] freq,
    output logic          accum_rst,
    output logic          sweep_start,
    output logic          busy,
    output logic          done
`ifdef NCO_SWEEP_CNT_EN
    ,
    input  logic [15:0]   cfg_count,
    output logic [15:0]   sweep_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [FW-1:0] start_q, stop_q, step_q;
    logic [DW-1:0] dwell_q, dwell_cnt, dwell_cnt_nxt, dwell_max;
    logic          repeat_q, dir_q;
    logic          load_cfg;
    logic [FW-1:0] freq_nxt;
    logic          accum_rst_nxt, sweep_start_nxt, busy_nxt, done_nxt;
    logic [FW:0]   sum_up, diff_dn;
    logic          end_of_sweep, limit_hit;

`ifdef NCO_SWEEP_CNT_EN
    logic [15:0]   count_q, sweep_cnt_nxt, cnt_inc;
`endif

    // Candidate next words carry one extra bit so overflow/underflow end the sweep instead of wrapping.
    always_comb begin
        sum_up       = {1'b0, freq} + {1'b0, step_q};
        diff_dn      = {1'b0, freq} - {1'b0, step_q};
        dwell_max    = (dwell_q == '0) ? '0 : dwell_q - DW'(1);
        end_of_sweep = (step_q == '0)
                    || (!dir_q && (sum_up > {1'b0, stop_q}))
                    || ( dir_q && ((freq < step_q) || (diff_dn < {1'b0, stop_q})));
    end

    // Completed-sweep counter and repeat limit.
`ifdef NCO_SWEEP_CNT_EN
    always_comb begin
        cnt_inc   = (sweep_cnt == 16'hFFFF) ? sweep_cnt : sweep_cnt + 16'd1;
        limit_hit = (count_q != 16'd0) && (cnt_inc >= count_q);
    end
`else
    assign limit_hit = 1'b0;
`endif

    // State register, registered outputs and latched configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            freq        <= '0;
            accum_rst   <= 1'b0;
            sweep_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            dwell_cnt   <= '0;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            repeat_q    <= 1'b0;
            dir_q       <= 1'b0;
`ifdef NCO_SWEEP_CNT_EN
            count_q     <= '0;
            sweep_cnt   <= '0;
`endif
        end else begin
            state       <= state_nxt;
            freq        <= freq_nxt;
            accum_rst   <= accum_rst_nxt;
            sweep_start <= sweep_start_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            dwell_cnt   <= dwell_cnt_nxt;
`ifdef NCO_SWEEP_CNT_EN
            sweep_cnt   <= sweep_cnt_nxt;
`endif
            if (load_cfg) begin
                start_q  <= cfg_start;
                stop_q   <= cfg_stop;
                step_q   <= cfg_step;
                dwell_q  <= cfg_dwell;
                repeat_q <= cfg_repeat;
                dir_q    <= (cfg_start > cfg_stop);
`ifdef NCO_SWEEP_CNT_EN
                count_q  <= cfg_count;
`endif
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        freq_nxt        = freq;
        accum_rst_nxt   = 1'b0;
        sweep_start_nxt = 1'b0;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        dwell_cnt_nxt   = dwell_cnt;
        load_cfg        = 1'b0;
`ifdef NCO_SWEEP_CNT_EN
        sweep_cnt_nxt   = sweep_cnt;
`endif
        if (abort) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        load_cfg        = 1'b1;
                        state_nxt       = RUN;
                        freq_nxt        = cfg_start;
                        accum_rst_nxt   = 1'b1;
                        sweep_start_nxt = 1'b1;
                        busy_nxt        = 1'b1;
                        dwell_cnt_nxt   = '0;
`ifdef NCO_SWEEP_CNT_EN
                        sweep_cnt_nxt   = '0;
`endif
                    end
                end
                RUN: begin
                    if (dwell_cnt >= dwell_max) begin
                        dwell_cnt_nxt = '0;
                        if (end_of_sweep) begin
`ifdef NCO_SWEEP_CNT_EN
                            sweep_cnt_nxt = cnt_inc;
`endif
                            if (repeat_q && !limit_hit) begin
                                freq_nxt        = start_q;
                                accum_rst_nxt   = 1'b1;
                                sweep_start_nxt = 1'b1;
                            end else begin
                                state_nxt = IDLE;
                                busy_nxt  = 1'b0;
                                done_nxt  = 1'b1;
                            end
                        end else begin
                            freq_nxt = dir_q ? diff_dn[FW-1:0] : sum_up[FW-1:0];
                        end
                    end else begin
                        dwell_cnt_nxt = dwell_cnt + DW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
